// File: rtl/adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : adder_pkg                                                   |
// | Description : Shared helpers for the sliced add/subtract pipeline:        |
// |               stage-count and slice-width functions plus the operation    |
// |               encoding that selects the stage-0 carry-in.                 |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package adder_pkg;

   // Operation select. OP_SUB forces the stage-0 carry-in to SUB_CARRY_IN so
   // that A + ~B + 1 forms A - B; OP_ADD passes the external cin through.
   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   localparam logic SUB_CARRY_IN = 1'b1;

   // Number of SEG-bit slices needed to cover WIDTH bits (ceiling division).
   function automatic int num_stages(input int width, input int seg);
      return (width + seg - 1) / seg;
   endfunction

   // Width of slice k. Every slice is SEG bits except the last, which takes
   // whatever is left over.
   function automatic int slice_width(input int k, input int width, input int seg);
      if (k == num_stages(width, seg) - 1)
         return width - k * seg;
      else
         return seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_addsub_slice.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_addsub_slice                                           |
// | Description : One registered W-bit adder slice with enable and            |
// |               carry-in/carry-out. Chained once per pipeline stage.        |
// | Ports       : clk, rst_n  - clock, async active-low reset                 |
// |               i_en        - capture enable (global pipeline advance)      |
// |               i_a, i_b    - slice operands (B already conditioned)        |
// |               i_ci        - carry into this slice                         |
// |               o_s, o_co   - registered slice sum and carry out            |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module pipe_addsub_slice
   import adder_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_ci,
   output logic [W-1:0] o_s,
   output logic         o_co
);

   logic [W:0] w_sum;
   logic [W-1:0] r_s;
   logic       r_co;

   assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_ci};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s  <= '0;
         r_co <= 1'b0;
      end else if (i_en) begin
         r_s  <= w_sum[W-1:0];
         r_co <= w_sum[W];
      end
   end

   assign o_s  = r_s;
   assign o_co = r_co;

endmodule

`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_addsub                                                 |
// | Description : Pipelined WIDTH-bit add/subtract split into SEG-bit         |
// |               carry-chained slices, one slice per stage, with a           |
// |               valid/ready handshake and a global stall.                   |
// | Ports       : clk, rst_n          - clock, async active-low reset         |
// |               in_valid, in_ready  - operand handshake                     |
// |               a, b, cin, sub      - operands; sub=1 gives A-B             |
// |               out_valid,out_ready - result handshake                      |
// |               s, cout, ovf        - result, carry/no-borrow, signed ovf   |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module pipe_addsub
   import adder_pkg::*;
#(
   parameter int WIDTH = 17,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = num_stages(WIDTH, SEG);

   op_e              w_op;
   logic [WIDTH-1:0] w_b_prep;
   logic             w_c0;
   logic             w_en;
   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] w_vld_next;
   logic [WIDTH-1:0] w_sum;
   logic             w_a_msb;
   logic             w_b_msb;

   // Operand conditioning: subtract is A + ~B + 1.
   assign w_op     = op_e'(sub);
   assign w_b_prep = (w_op == OP_SUB) ? ~b : b;
   assign w_c0     = (w_op == OP_SUB) ? SUB_CARRY_IN : cin;

   // Whole pipeline advances together; it only stalls when the last stage
   // holds a result the consumer is not taking. Bubbles are not squeezed out.
   assign w_en     = ~r_vld[STAGES-1] | out_ready;
   assign in_ready = w_en;

   if (STAGES == 1) begin : g_vld_single
      assign w_vld_next = in_valid;
   end else begin : g_vld_shift
      assign w_vld_next = {r_vld[STAGES-2:0], in_valid};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_vld <= '0;
      else if (w_en)
         r_vld <= w_vld_next;
   end

   assign out_valid = r_vld[STAGES-1];

   // Stage k consumes the operand bits from slice k upward. It adds its own
   // slice and forwards only the still-unprocessed upper bits (or, in the
   // last stage, just the operand MSBs needed for the overflow flag). Lower
   // sums already computed ride along in r_low so the full result lines up
   // at the last stage.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int c_lsb  = k * SEG;
      localparam int c_sw   = slice_width(k, WIDTH, SEG);
      localparam int c_opw  = WIDTH - c_lsb;
      localparam int c_keep = (k == STAGES - 1) ? 1 : c_opw - c_sw;

      logic [c_opw-1:0]       w_op_a;
      logic [c_opw-1:0]       w_op_b;
      logic                   w_ci;
      logic [c_sw-1:0]        w_slice_s;
      logic                   w_co;
      logic [c_keep-1:0]      r_keep_a;
      logic [c_keep-1:0]      r_keep_b;
      logic [c_lsb+c_sw-1:0]  w_acc;

      if (k == 0) begin : g_head
         assign w_op_a = a;
         assign w_op_b = w_b_prep;
         assign w_ci   = w_c0;
         assign w_acc  = w_slice_s;
      end else begin : g_tail
         logic [c_lsb-1:0] r_low;

         assign w_op_a = g_stage[k-1].r_keep_a;
         assign w_op_b = g_stage[k-1].r_keep_b;
         assign w_ci   = g_stage[k-1].w_co;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_low <= '0;
            else if (w_en)
               r_low <= g_stage[k-1].w_acc;
         end

         assign w_acc = {w_slice_s, r_low};
      end

      if (k == STAGES - 1) begin : g_last
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_keep_a <= '0;
               r_keep_b <= '0;
            end else if (w_en) begin
               r_keep_a <= w_op_a[c_opw-1];
               r_keep_b <= w_op_b[c_opw-1];
            end
         end
      end else begin : g_skew
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_keep_a <= '0;
               r_keep_b <= '0;
            end else if (w_en) begin
               r_keep_a <= w_op_a[c_opw-1:c_sw];
               r_keep_b <= w_op_b[c_opw-1:c_sw];
            end
         end
      end

      pipe_addsub_slice #(
         .W (c_sw)
      ) u_slice (
         .clk   (clk),
         .rst_n (rst_n),
         .i_en  (w_en),
         .i_a   (w_op_a[c_sw-1:0]),
         .i_b   (w_op_b[c_sw-1:0]),
         .i_ci  (w_ci),
         .o_s   (w_slice_s),
         .o_co  (w_co)
      );
   end

   assign w_sum   = g_stage[STAGES-1].w_acc;
   assign w_a_msb = g_stage[STAGES-1].r_keep_a[0];
   assign w_b_msb = g_stage[STAGES-1].r_keep_b[0];

   assign s    = w_sum;
   assign cout = g_stage[STAGES-1].w_co;
   // Same-sign operands whose result sign differs: signed overflow.
   assign ovf  = (w_a_msb == w_b_msb) & (w_sum[WIDTH-1] != w_a_msb);

endmodule

`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_addsub                                              |
// | Description : Self-checking bench for pipe_addsub (WIDTH=17, SEG=8).      |
// |               Directed vectors, backpressure, random stream, mid-reset.   |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_pipe_addsub;

   localparam int WIDTH = 17;
   localparam int SEG   = 8;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   int n_checks;
   int n_fail;

   pipe_addsub #(
      .WIDTH (WIDTH),
      .SEG   (SEG)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference result {ovf, cout, s} from integer arithmetic.
   function automatic logic [31:0] golden(input logic [16:0] av, input logic [16:0] bv,
                                          input logic cv, input logic sv);
      int ua, ub, sa, sb, ures, sres;
      logic [16:0] rs;
      logic        rc, ro;
      ua = int'(av);
      ub = int'(bv);
      sa = av[16] ? ua - 131072 : ua;
      sb = bv[16] ? ub - 131072 : ub;
      if (sv) begin
         ures = ua - ub;
         rc   = (ua >= ub);
         sres = sa - sb;
      end else begin
         ures = ua + ub + int'(cv);
         rc   = (ures >= 131072);
         sres = sa + sb + int'(cv);
      end
      rs = 17'(ures);
      ro = (sres > 65535) || (sres < -65536);
      return {13'd0, ro, rc, rs};
   endfunction

   function automatic logic [16:0] pick_operand();
      logic [16:0] edges [4];
      edges[0] = 17'h00000;
      edges[1] = 17'h1FFFF;
      edges[2] = 17'h0FFFF;
      edges[3] = 17'h10000;
      if ($urandom_range(0, 4) == 0)
         return edges[$urandom_range(0, 3)];
      return 17'($urandom);
   endfunction

   // One isolated beat: checks latency of exactly three cycles and the result.
   task automatic run_one(input string tag, input logic [16:0] av, input logic [16:0] bv,
                          input logic cv, input logic sv,
                          input logic [16:0] es, input logic ec, input logic eo);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = av; b = bv; cin = cv; sub = sv;
      #1;
      check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
      tick();
      check_eq({tag, "_lat2"}, 32'(out_valid), 32'd0);
      tick();
      check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_s"}, 32'(s), 32'(es));
      check_eq({tag, "_cout"}, 32'(cout), 32'(ec));
      check_eq({tag, "_ovf"}, 32'(ovf), 32'(eo));
      tick();
      check_eq({tag, "_drain"}, 32'(out_valid), 32'd0);
   endtask

   logic [16:0] bp_a   [4];
   logic [16:0] bp_b   [4];
   logic [31:0] bp_exp [4];
   logic [31:0] exp_q  [$];

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;

      // ---------------- reset state ----------------
      repeat (3) tick();
      rst_n = 1'b1;
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_s", 32'(s), 32'd0);
      check_eq("rst_cout", 32'(cout), 32'd0);
      check_eq("rst_ovf", 32'(ovf), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      tick();

      // ---------------- directed vectors ----------------
      run_one("add_wrap",   17'h1FFFF, 17'h00001, 1'b0, 1'b0, 17'h00000, 1'b1, 1'b0);
      run_one("add_ovf",    17'h0FFFF, 17'h00001, 1'b0, 1'b0, 17'h10000, 1'b0, 1'b1);
      run_one("sub_neg",    17'h00005, 17'h00007, 1'b1, 1'b1, 17'h1FFFE, 1'b0, 1'b0);
      run_one("sub_pos",    17'h00007, 17'h00005, 1'b0, 1'b1, 17'h00002, 1'b1, 1'b0);
      run_one("add_negovf", 17'h10000, 17'h10000, 1'b0, 1'b0, 17'h00000, 1'b1, 1'b1);
      run_one("sub_ovf",    17'h0FFFF, 17'h10000, 1'b0, 1'b1, 17'h1FFFF, 1'b0, 1'b1);
      run_one("add_cin",    17'h000FF, 17'h00000, 1'b1, 1'b0, 17'h00100, 1'b0, 1'b0);

      // ---------------- backpressure ----------------
      bp_a[0] = 17'h00010; bp_b[0] = 17'h00020; bp_exp[0] = 32'h00030;
      bp_a[1] = 17'h000F0; bp_b[1] = 17'h00010; bp_exp[1] = 32'h00100;
      bp_a[2] = 17'h1FF00; bp_b[2] = 17'h00100; bp_exp[2] = 32'h20000;
      bp_a[3] = 17'h0FF00; bp_b[3] = 17'h00100; bp_exp[3] = 32'h50000;
      out_ready = 1'b0;
      cin = 1'b0; sub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = bp_a[i]; b = bp_b[i];
         #1;
         check_eq("bp_accept", 32'(in_ready), 32'd1);
         tick();
      end
      in_valid = 1'b1; a = bp_a[3]; b = bp_b[3];
      #1;
      check_eq("bp_full_rdy", 32'(in_ready), 32'd0);
      check_eq("bp_full_vld", 32'(out_valid), 32'd1);
      check_eq("bp_full_res", {13'd0, ovf, cout, s}, bp_exp[0]);
      for (int i = 0; i < 2; i++) begin
         tick();
         check_eq("bp_hold_rdy", 32'(in_ready), 32'd0);
         check_eq("bp_hold_res", {13'd0, ovf, cout, s}, bp_exp[0]);
      end
      out_ready = 1'b1;
      #1;
      check_eq("bp_release_rdy", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         check_eq("bp_drain_vld", 32'(out_valid), 32'd1);
         check_eq("bp_drain_res", {13'd0, ovf, cout, s}, bp_exp[i]);
         tick();
      end
      check_eq("bp_empty", 32'(out_valid), 32'd0);

      // ---------------- random stream ----------------
      begin
         int sent;
         int cyc;
         logic [31:0] exp_v;
         sent = 0;
         cyc  = 0;
         exp_q.delete();
         while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
               in_valid = 1'b1;
               a   = pick_operand();
               b   = pick_operand();
               cin = 1'($urandom);
               sub = 1'($urandom);
            end else begin
               in_valid = 1'b0;
            end
            #1;
            check_eq("rand_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (in_valid && in_ready) begin
               exp_q.push_back(golden(a, b, cin, sub));
               sent++;
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check_eq("rand_extra", 32'd1, 32'd0);
               end else begin
                  exp_v = exp_q.pop_front();
                  check_eq("rand_res", {13'd0, ovf, cout, s}, exp_v);
               end
            end
            tick();
            cyc++;
         end
         in_valid = 1'b0;
         check_eq("rand_budget", 32'(cyc < 20000), 32'd1);
         check_eq("rand_sent", 32'(sent), 32'd1000);
         check_eq("rand_q_empty", 32'(exp_q.size()), 32'd0);
      end

      // ---------------- reset mid-stream ----------------
      begin
         int stale;
         out_ready = 1'b1;
         sub = 1'b0; cin = 1'b0;
         tick();
         in_valid = 1'b1; a = 17'h00001; b = 17'h00002;
         tick();
         in_valid = 1'b1; a = 17'h00003; b = 17'h00004;
         tick();
         in_valid = 1'b0;
         tick();
         check_eq("mid_pre_vld", 32'(out_valid), 32'd1);
         #2;
         rst_n = 1'b0;
         #1;
         check_eq("mid_async_vld", 32'(out_valid), 32'd0);
         check_eq("mid_async_s", 32'(s), 32'd0);
         tick();
         rst_n = 1'b1;
         #1;
         check_eq("mid_rel_rdy", 32'(in_ready), 32'd1);
         stale = 0;
         for (int i = 0; i < 6; i++) begin
            if (out_valid) stale++;
            tick();
         end
         check_eq("mid_no_stale", 32'(stale), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
